// File: rtl/lib_switchblock_pkg.sv
// lib_switchblock_pkg: shared types, sizes and the code clamp used by the DEM sequencer and switching tree.
package lib_switchblock_pkg;
  localparam int INPUT_WIDTH = 8;
  localparam int DATA_W = INPUT_WIDTH;
  localparam int SEQ_MAX_MAG = 8;
  localparam int SEQ_TREE_LAT = 3;
  localparam int SEQ_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {SEQ_IDLE = 2'd0, SEQ_FILL = 2'd1, SEQ_RUN = 2'd2, SEQ_FLUSH = 2'd3} seq_state_t;
  typedef struct packed {
    logic clip;
    logic signed [DATA_W-1:0] code;
  } clamp_t;
  // Saturate a signed code to [-max_mag, +max_mag]; the most negative code saturates too.
  function automatic clamp_t seq_clamp(input logic signed [DATA_W-1:0] x, input int max_mag);
    clamp_t r;
    r.clip = (int'(x) > max_mag) || (int'(x) < -max_mag);
    r.code = int'(x) > max_mag ? DATA_W'(max_mag) : int'(x) < -max_mag ? DATA_W'(-max_mag) : x;
    return r;
  endfunction
endpackage

// File: rtl/dem_tree_sequencer_if.sv
// dem_tree_sequencer_if: upstream valid/ready sample stream into the DEM sequencer.
//   s_valid: sample offered, s_data: signed code, s_ready: sequencer accepts.
interface dem_tree_sequencer_if;
  import lib_switchblock_pkg::*;
  logic s_valid;
  logic s_ready;
  logic signed [DATA_W-1:0] s_data;
  modport master(output s_valid, output s_data, input s_ready);
  modport slave(input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dem_tree_sequencer_fifo.sv
// dem_seq_fifo: small synchronous FIFO with push/pop/clear, full/empty flags and occupancy count.
//   clk_i, reset_i (async active-low), clear_i, push_i/din_i, pop_i/dout_o, full_o, empty_o, count_o.
module dem_seq_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 din_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [QW-1:0] cnt_q;
  logic push_ok, pop_ok;
  assign full_o = cnt_q == QW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign push_ok = push_i & !full_o;
  assign pop_ok = pop_i & !empty_o;
  always_ff @(posedge clk_i)
    if (push_ok) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i || clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + QW'(push_ok) - QW'(pop_ok);
    end
endmodule

// File: rtl/dem_tree_sequencer.sv
// dem_tree_sequencer: buffers signed DAC codes and issues one clamped code per sample tick into the DEM tree.
//   clk_i, reset_i (async active-low), enable_i (run request), sample_tick_i (DAC strobe), s_if (upstream stream),
//   tree_x_o/tree_adv_o (issued code + pulse), tree_valid_o (tree output carries a sample), state_o, busy_o,
//   clip_o/underrun_o (pulses), err_o (sticky underrun in RUN).
//   Define DEM_TREE_SEQ_STATS_EN to add saturating underrun_cnt_o/clip_cnt_o counters.
module dem_tree_sequencer import lib_switchblock_pkg::*; #(
  parameter int MAX_MAG = SEQ_MAX_MAG,
  parameter int TREE_LAT = SEQ_TREE_LAT,
  parameter int FIFO_DEPTH = SEQ_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     sample_tick_i,
  dem_tree_sequencer_if.slave      s_if,
  output logic signed [DATA_W-1:0] tree_x_o,
  output logic                     tree_adv_o,
  output logic                     tree_valid_o,
  output logic [1:0]               state_o,
  output logic                     busy_o,
  output logic                     clip_o,
  output logic                     underrun_o,
`ifdef DEM_TREE_SEQ_STATS_EN
  output logic [15:0]              underrun_cnt_o,
  output logic [15:0]              clip_cnt_o,
`endif
  output logic                     err_o
);
  localparam int CW = $clog2(TREE_LAT + 1);
  localparam int QW = $clog2(FIFO_DEPTH + 1);
  seq_state_t state_q;
  logic [CW-1:0] fill_cnt_q, flush_cnt_q;
  logic [TREE_LAT-1:0] vld_sr_q;
  logic signed [DATA_W-1:0] tree_x_q, head;
  logic adv_q, clip_q, und_q, err_q;
  logic full, empty, active, push, pop, clear, start;
  logic [QW-1:0] count;
  clamp_t head_c;
  assign active = state_q inside {SEQ_FILL, SEQ_RUN};
  assign s_if.s_ready = reset_i & enable_i & !full & (state_q != SEQ_FLUSH);
  assign push = s_if.s_valid & s_if.s_ready;
  assign clear = active & !enable_i;
  assign pop = active & enable_i & sample_tick_i & !empty;
  assign start = (state_q == SEQ_IDLE) & enable_i & (count != '0);
  assign head_c = seq_clamp(head, MAX_MAG);
  dem_seq_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (s_if.s_data),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // A tick coincident with enable dropping shifts in 0 (flush zero) but is not counted as a flush tick.
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state_q <= SEQ_IDLE;
      fill_cnt_q <= '0;
      flush_cnt_q <= '0;
      vld_sr_q <= '0;
      tree_x_q <= '0;
      adv_q <= 1'b0;
      clip_q <= 1'b0;
      und_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      adv_q <= 1'b0;
      clip_q <= 1'b0;
      und_q <= 1'b0;
      case (state_q)
        SEQ_IDLE:
          if (start) begin
            state_q <= SEQ_FILL;
            fill_cnt_q <= '0;
            err_q <= 1'b0;
          end
        SEQ_FILL, SEQ_RUN: begin
          if (sample_tick_i) begin
            adv_q <= 1'b1;
            vld_sr_q <= {vld_sr_q[TREE_LAT-2:0], enable_i};
            tree_x_q <= pop ? head_c.code : '0;
            clip_q <= pop & head_c.clip;
            und_q <= enable_i & empty;
          end
          if (!enable_i) begin
            state_q <= SEQ_FLUSH;
            flush_cnt_q <= '0;
          end else if (sample_tick_i) begin
            if (empty && state_q == SEQ_RUN) err_q <= 1'b1;
            if (state_q == SEQ_FILL) begin
              fill_cnt_q <= fill_cnt_q + 1'b1;
              if (fill_cnt_q == CW'(TREE_LAT - 1)) state_q <= SEQ_RUN;
            end
          end
        end
        default:
          if (sample_tick_i) begin
            adv_q <= 1'b1;
            tree_x_q <= '0;
            vld_sr_q <= {vld_sr_q[TREE_LAT-2:0], 1'b0};
            flush_cnt_q <= flush_cnt_q + 1'b1;
            if (flush_cnt_q == CW'(TREE_LAT - 1)) state_q <= SEQ_IDLE;
          end
      endcase
    end
`ifdef DEM_TREE_SEQ_STATS_EN
  logic [15:0] und_cnt_q, clip_cnt_q;
  logic und_set, clip_set;
  assign und_set = active & enable_i & sample_tick_i & empty;
  assign clip_set = pop & head_c.clip;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i || start) begin
      und_cnt_q <= '0;
      clip_cnt_q <= '0;
    end else begin
      if (und_set && und_cnt_q != 16'hFFFF) und_cnt_q <= und_cnt_q + 1'b1;
      if (clip_set && clip_cnt_q != 16'hFFFF) clip_cnt_q <= clip_cnt_q + 1'b1;
    end
  assign underrun_cnt_o = und_cnt_q;
  assign clip_cnt_o = clip_cnt_q;
`endif
  assign tree_x_o = tree_x_q;
  assign tree_adv_o = adv_q;
  assign tree_valid_o = vld_sr_q[TREE_LAT-1];
  assign state_o = state_q;
  assign busy_o = state_q != SEQ_IDLE;
  assign clip_o = clip_q;
  assign underrun_o = und_q;
  assign err_o = err_q;
endmodule
